mul_sequencer: RTL
==================

# mul_sequencer

Multi-cycle controller that computes ARM MUL/MLA (low 32 bits) by driving the shared execute-stage ALU with a shift-and-add sequence, one multiplier bit per cycle. It sits beside the EXE stage: while it runs it owns the ALU inputs via `alu_sel`, stalls the pipeline, and on completion returns the result and optional N/Z flag update to the status register.

## Interface
Parameters:
- `REGISTER_LEN`, 32, datapath width (from `defines.v`)
- `EXECUTE_COMMAND_LEN`, 4, ALU command width (from `defines.v`)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  MUL/MLA present in EXE; sampled only in IDLE
- `accumulate`  in  1  1 = MLA (add `rn`), 0 = MUL
- `set_status`  in  1  S bit; flags written on completion when 1
- `rm`, `rs`, `rn`  in  32 each  multiplicand, multiplier, accumulate operand
- `status_register`  in  4  current flags, order {Z,C,N,V}
- `alu_out`  in  32  shared ALU result
- `alu_sel`  out  1  1 = ALU inputs taken from this block
- `alu_in1`, `alu_in2`  out  32 each  ALU operands
- `alu_command`  out  `EXECUTE_COMMAND_LEN`  ALU command
- `result`  out  32  product (valid when `done`)
- `status_out`  out  4  new flags {Z,C,N,V}
- `status_we`  out  1  flag write enable, one cycle
- `done`  out  1  one-cycle completion pulse
- `stall`  out  1  holds IF/ID/EXE pipeline registers

## Operation
- States: IDLE, RUN, DONE.
- IDLE & `start`: latch acc = `accumulate` ? `rn` : 0, mcand = `rm`, mplier = `rs`, s_q = `set_status`, cv_q = {C,V} of `status_register`, count = 0; go RUN. `start` outside IDLE is ignored.
- RUN, each cycle: `alu_sel`=1, `alu_in1`=acc, `alu_in2`=mcand, `alu_command`=`ADD`. At edge: if mplier[0], acc <= `alu_out`; mcand <= mcand << 1; mplier <= mplier >> 1; count++.
- RUN exit: go DONE when (mplier >> 1) == 0 or count == 31; otherwise stay.
- DONE: `done`=1, `result`=acc, `status_we`=s_q, `status_out`={acc==0, cv_q[1], acc[31], cv_q[0]}; next edge -> IDLE.
- Arithmetic: modulo 2^32; ALU carry/overflow ignored. C and V preserved from the value latched at start.
- Outside RUN: `alu_sel`=0, `alu_in1`=`alu_in2`=0, `alu_command`=`MOV`.
- `stall` = (IDLE & `start`) | RUN. Low in DONE so the pipeline advances with `result` that cycle.

## Timing
- Reset: state IDLE; acc, mcand, mplier, count, s_q, cv_q = 0; all outputs 0 (`result`=0, `status_out`=0, `done`=`status_we`=`stall`=`alu_sel`=0).
- RUN length k = max(1, index of highest set bit of `rs` + 1), 1..32 cycles.
- Start sampled at edge E0 -> RUN for k cycles -> DONE in cycle k+1 after E0; total stall k+1 cycles counting the start cycle.
- `rs`=0: k=1, result = acc initial value.
- `rst` mid-RUN or in DONE: IDLE next edge, no `done`, no `status_we`.
- `start` asserted in DONE: ignored; pipeline must re-present after IDLE.
- `done` and `status_we` never exceed one cycle.

## Structure
- `defines.v`: add `MUL_IDLE`, `MUL_RUN`, `MUL_DONE` (2-bit encodings) and `MUL_COUNT_LEN` (5); reuse `ADD`/`MOV` from `inst_defs.v`, flag indices from `defines.v`.
- Single module, no sub-module; the ALU and the EXE-stage input mux controlled by `alu_sel` live outside.

## Test plan
- MUL `rm`=6, `rs`=7, S=1, status {0,1,0,1}: 3 RUN cycles, `done` at E0+4, `result`=42, `status_out`={0,1,0,1}, `status_we`=1.
- MLA `rm`=5, `rs`=0, `rn`=9, S=0: k=1, `result`=9, `status_we`=0, `stall` high exactly 2 cycles.
- MUL `rm`=`rs`=0xFFFFFFFF: 32 RUN cycles, `result`=1, Z=0, N=0.
- MUL `rm`=0x80000000, `rs`=1, S=1: `result`=0x80000000, N=1; `rm`=0x10000, `rs`=0x10000: `result`=0, Z=1, C/V unchanged.
- `start` re-pulsed during RUN and DONE: ignored, single `done`, result of first operands.
- `rst` asserted on 3rd RUN cycle of a 32-cycle op: IDLE next edge, all outputs 0, no `done`; fresh start then completes correctly.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// Shared types and constants for the shift-and-add MUL/MLA sequencer.
package mul_sequencer_pkg;

  localparam int unsigned REGISTER_LEN_DEF        = 32;
  localparam int unsigned EXECUTE_COMMAND_LEN_DEF = 4;
  localparam int unsigned MUL_COUNT_LEN           = 5;
  localparam int unsigned STATUS_LEN              = 4;

  // Flag positions inside the {Z,C,N,V} status word
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [EXECUTE_COMMAND_LEN_DEF-1:0] ALU_CMD_MOV = 4'b0001;
  localparam logic [EXECUTE_COMMAND_LEN_DEF-1:0] ALU_CMD_ADD = 4'b0010;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL/MLA controller: borrows the EXE-stage ALU for one
// shift-and-add step per multiplier bit while stalling the pipeline.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int unsigned REGISTER_LEN        = REGISTER_LEN_DEF,
  parameter int unsigned EXECUTE_COMMAND_LEN = EXECUTE_COMMAND_LEN_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           accumulate,
  input  logic                           set_status,
  input  logic [REGISTER_LEN-1:0]        rm,
  input  logic [REGISTER_LEN-1:0]        rs,
  input  logic [REGISTER_LEN-1:0]        rn,
  input  logic [STATUS_LEN-1:0]          status_register,
  input  logic [REGISTER_LEN-1:0]        alu_out,
  output logic                           alu_sel,
  output logic [REGISTER_LEN-1:0]        alu_in1,
  output logic [REGISTER_LEN-1:0]        alu_in2,
  output logic [EXECUTE_COMMAND_LEN-1:0] alu_command,
  output logic [REGISTER_LEN-1:0]        result,
  output logic [STATUS_LEN-1:0]          status_out,
  output logic                           status_we,
  output logic                           done,
  output logic                           stall
);

  mul_state_e               r_state;
  mul_state_e               w_next_state;
  logic [REGISTER_LEN-1:0]  r_acc;
  logic [REGISTER_LEN-1:0]  r_mcand;
  logic [REGISTER_LEN-1:0]  r_mplier;
  logic [MUL_COUNT_LEN-1:0] r_count;
  logic                     r_s;
  logic [1:0]               r_cv;
  logic                     w_last_step;

  // Stop once no higher multiplier bits remain, or after the 32nd step
  assign w_last_step = ((r_mplier >> 1) == '0) || (r_count == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MUL_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    alu_sel      = 1'b0;
    alu_in1      = '0;
    alu_in2      = '0;
    alu_command  = EXECUTE_COMMAND_LEN'(ALU_CMD_MOV);
    result       = '0;
    status_out   = '0;
    status_we    = 1'b0;
    done         = 1'b0;
    stall        = 1'b0;
    unique case (r_state)
      MUL_IDLE: begin
        stall = start;
        if (start) begin
          w_next_state = MUL_RUN;
        end
      end
      MUL_RUN: begin
        stall       = 1'b1;
        alu_sel     = 1'b1;
        alu_in1     = r_acc;
        alu_in2     = r_mcand;
        alu_command = EXECUTE_COMMAND_LEN'(ALU_CMD_ADD);
        if (w_last_step) begin
          w_next_state = MUL_DONE;
        end
      end
      MUL_DONE: begin
        done                 = 1'b1;
        result               = r_acc;
        status_we            = r_s;
        status_out[FLAG_Z]   = (r_acc == '0);
        status_out[FLAG_C]   = r_cv[1];
        status_out[FLAG_N]   = r_acc[REGISTER_LEN-1];
        status_out[FLAG_V]   = r_cv[0];
        w_next_state         = MUL_IDLE;
      end
      default: begin
        w_next_state = MUL_IDLE;
      end
    endcase
  end

  // Operand latch and one shift-and-add step per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_s      <= 1'b0;
      r_cv     <= '0;
    end else begin
      unique case (r_state)
        MUL_IDLE: begin
          if (start) begin
            r_acc    <= accumulate ? rn : '0;
            r_mcand  <= rm;
            r_mplier <= rs;
            r_count  <= '0;
            r_s      <= set_status;
            r_cv     <= {status_register[FLAG_C], status_register[FLAG_V]};
          end
        end
        MUL_RUN: begin
          if (r_mplier[0]) begin
            r_acc <= alu_out;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + MUL_COUNT_LEN'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
